dm_responder: RTL and testbench



---
 rtl/dm_responder.sv | 167 ++++++++++++++++
 tb/tb_dm_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: RV32I data-memory responder with byte lanes, sign/zero extension and fixed access latency.
// Optional define DM_MISALIGN_TRAP_EN reports misaligned half/word accesses as errors instead of aligning down.
module dm_responder #(
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [2:0]         funct3_q;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               accept, commit;

  logic [31:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  idx;
  logic [1:0]         off;
  logic               illegal, misalign, fault;
  logic [3:0]         be;
  logic [31:0]        wword, rword, load_val;
  logic [7:0]         byte_sh;
  logic [15:0]        half_sh;
  logic               unused_addr_hi;

  // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH*4.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign idx     = addr_q[ADDR_W+1:2];
  assign off     = addr_q[1:0];
  assign rword   = mem[idx];
  assign illegal = (funct3_q[1:0] == 2'b11) || (funct3_q == 3'b110) || (we_q && funct3_q[2]);
`ifdef DM_MISALIGN_TRAP_EN
  assign misalign = ((funct3_q[1:0] == 2'b01) && off[0]) ||
                    ((funct3_q[1:0] == 2'b10) && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign fault   = illegal || misalign;

  // Store data is replicated across lanes so each enabled lane picks up the right bytes.
  always_comb begin
    be    = 4'b0000;
    wword = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be[off] = 1'b1;
        wword   = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign byte_sh = 8'(rword >> {off, 3'b000});
  assign half_sh = 16'(rword >> {off[1], 4'b0000});

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{byte_sh[7] & ~funct3_q[2]}}, byte_sh};
      2'b01:   load_val = {{16{half_sh[15] & ~funct3_q[2]}}, half_sh};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          valid_d = 1'b1;
          err_d   = fault;
          rdata_d = (fault || we_q) ? 32'h0 : load_val;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      addr_q   <= req_addr[ADDR_W+1:0];
      wdata_q  <= req_wdata;
      funct3_q <= req_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed vector table, reset/backpressure sequences, randomized loads/stores vs a byte-level model.
module tb_dm_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_funct3;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [2:0]  b_req_funct3;

  dm_responder #(.DEPTH(512), .ADDR_W(9), .LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH(512), .ADDR_W(9), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_funct3(b_req_funct3),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] mdl [512];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic void add(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // Reference model: byte-addressed memory semantics from the RV32I load/store rules.
  function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int unsigned a, wi, size, bo;
    logic        bad;
    logic [31:0] val;
    a    = addr;
    wi   = (a / 4) % 512;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
`ifdef DM_MISALIGN_TRAP_EN
    if (!bad && (a % size) != 0) bad = 1'b1;
`endif
    rd  = 32'h0;
    err = bad;
    if (bad) return;
    bo = (a % 4) - ((a % 4) % size);
    if (we) begin
      for (int k = 0; k < int'(size); k++) mdl[wi][8*(int'(bo)+k) +: 8] = wdata[8*k +: 8];
    end else begin
      val = 32'h0;
      for (int k = 0; k < int'(size); k++) val = val | (32'(mdl[wi][8*(int'(bo)+k) +: 8]) << (8*k));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
      rd = val;
    end
  endfunction

  task automatic txn1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    $display("txn we=%0d f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
             we, f3, addr, wdata, rd, er, lat);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  logic [31:0] rd, exp_rd, w;
  logic        er, exp_er;
  int          lat;

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0; resp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_funct3 = 0; b_resp_ready = 0;

    add("sw10",   1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0, 0);
    add("lw10",   0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add("sw10z",  1, 3'b010, 32'h10,  32'h0,        32'h0, 0);
    add("sb11",   1, 3'b000, 32'h11,  32'h000000A5, 32'h0, 0);
    add("lw10b",  0, 3'b010, 32'h10,  32'h0,        32'h0000A500, 0);
    add("lb11",   0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFA5, 0);
    add("lbu11",  0, 3'b100, 32'h11,  32'h0,        32'h000000A5, 0);
`ifdef DM_MISALIGN_TRAP_EN
    add("lw13",   0, 3'b010, 32'h13,  32'h0,        32'h0, 1);
`else
    add("lw13",   0, 3'b010, 32'h13,  32'h0,        32'h0000A500, 0);
`endif
    add("sw20z",  1, 3'b010, 32'h20,  32'h0,        32'h0, 0);
    add("sh22",   1, 3'b001, 32'h22,  32'h00008001, 32'h0, 0);
    add("lh22",   0, 3'b001, 32'h22,  32'h0,        32'hFFFF8001, 0);
    add("lhu22",  0, 3'b101, 32'h22,  32'h0,        32'h00008001, 0);
    add("lw20",   0, 3'b010, 32'h20,  32'h0,        32'h80010000, 0);
`ifdef DM_MISALIGN_TRAP_EN
    add("lh23",   0, 3'b001, 32'h23,  32'h0,        32'h0, 1);
`else
    add("lh23",   0, 3'b001, 32'h23,  32'h0,        32'hFFFF8001, 0);
`endif
    add("sw30",   1, 3'b010, 32'h30,  32'h12345678, 32'h0, 0);
    add("st011",  1, 3'b011, 32'h30,  32'hFFFFFFFF, 32'h0, 1);
    add("lw30",   0, 3'b010, 32'h30,  32'h0,        32'h12345678, 0);
    add("st100",  1, 3'b100, 32'h30,  32'hFFFFFFFF, 32'h0, 1);
    add("ld110",  0, 3'b110, 32'h30,  32'h0,        32'h0, 1);
    add("lw30b",  0, 3'b010, 32'h30,  32'h0,        32'h12345678, 0);
    add("sw800",  1, 3'b010, 32'h800, 32'hCAFEF00D, 32'h0, 0);
    add("lw0",    0, 3'b010, 32'h0,   32'h0,        32'hCAFEF00D, 0);

    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      txn1(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
      check({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
    end

    // Reset in the middle of a store must leave the word untouched.
    txn1(1'b1, 3'b010, 32'h40, 32'h0BADF00D, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_mid_busy", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_valid0", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_valid1", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn1(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    check("rst_mid_lw40", rd, 32'h0BADF00D);

    // Backpressure on the LATENCY=3 instance.
    @(negedge clk);
    b_req_valid = 1; b_req_we = 1; b_req_funct3 = 3'b010; b_req_addr = 32'h50; b_req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    b_req_valid = 0;
    lat = 0;
    while (!b_resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_sw_lat", 32'(lat), 32'd3);
    check("bp_sw_rdata", b_resp_rdata, 32'h0);
    b_resp_ready = 1;
    @(posedge clk);
    #1;
    b_resp_ready = 0;
    @(negedge clk);
    b_req_valid = 1; b_req_we = 0; b_req_funct3 = 3'b010; b_req_addr = 32'h50;
    @(posedge clk);
    #1;
    check("bp_busy", {31'b0, b_req_ready}, 32'd0);
    lat = 0;
    while (!b_resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_lw_lat", 32'(lat), 32'd3);
    check("bp_lw_rdata", b_resp_rdata, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'b0, b_resp_valid}, 32'd1);
      check("bp_hold_rdata", b_resp_rdata, 32'h11223344);
      check("bp_hold_req_ready", {31'b0, b_req_ready}, 32'd0);
    end
    $display("txn bp lw addr=00000050 rdata=%08h held 5 cycles", b_resp_rdata);
    b_resp_ready = 1;
    @(posedge clk);
    #1;
    b_resp_ready = 0;
    check("bp_after_hs_valid", {31'b0, b_resp_valid}, 32'd0);
    check("bp_after_hs_ready", {31'b0, b_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    b_req_valid = 0;
    check("bp_next_accepted", {31'b0, b_req_ready}, 32'd0);
    lat = 0;
    while (!b_resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_next_lat", 32'(lat), 32'd3);
    check("bp_next_rdata", b_resp_rdata, 32'h11223344);
    b_resp_ready = 1;
    @(posedge clk);
    #1;
    b_resp_ready = 0;

    // Randomized traffic over words 0x100..0x10F with random (ignored) upper address bits.
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      ref_access(1'b1, 3'b010, 32'h400 + 32'(4*i), w, exp_rd, exp_er);
      txn1(1'b1, 3'b010, 32'h400 + 32'(4*i), w, rd, er, lat);
    end
    for (int i = 0; i < 200; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_hi;
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_hi   = $urandom;
      r_addr = (r_hi & 32'hFFFF_F800) | (32'h400 + 32'($urandom_range(0, 63)));
      w      = $urandom;
      ref_access(r_we, r_f3, r_addr, w, exp_rd, exp_er);
      txn1(r_we, r_f3, r_addr, w, rd, er, lat);
      check("rand_rdata", rd, exp_rd);
      check("rand_err", {31'b0, er}, {31'b0, exp_er});
      check("rand_lat", 32'(lat), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
